// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks req/ack to instruction memory,
// buffers one instruction for IF/ID and raises the IF/ID flush for bubbles.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] Instruction_o,
    output logic        valid_o,
    output logic        ifid_flush_o
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] HOLD  = 2'd1;
    localparam logic [1:0] DROP  = 2'd2;

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] instPc_q, instPc_d;
    logic        valid_q, valid_d;
    logic [1:0]  state_q, state_d;
    logic [31:0] dropAddr_q, dropAddr_d;

    always_comb begin
        pc_d       = pc_q;
        inst_d     = inst_q;
        instPc_d   = instPc_q;
        valid_d    = valid_q;
        state_d    = state_q;
        dropAddr_d = dropAddr_q;
        if (branch_i) begin
            // A request already in flight must keep its address until acked,
            // so the redirect waits in DROP while the PC moves ahead.
            pc_d    = {branch_target_i[31:2], 2'b00};
            valid_d = 1'b0;
            case (state_q)
                FETCH: begin
                    if (imem_ack_i) begin
                        state_d = FETCH;
                    end else begin
                        state_d    = DROP;
                        dropAddr_d = pc_q;
                    end
                end
                DROP:    state_d = imem_ack_i ? FETCH : DROP;
                default: state_d = FETCH;
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_ack_i) begin
                        inst_d   = imem_data_i;
                        instPc_d = pc_q;
                        valid_d  = 1'b1;
                        state_d  = HOLD;
                    end
                end
                HOLD: begin
                    if (!stall_i) begin
                        valid_d = 1'b0;
                        pc_d    = pc_q + 32'd4;
                        state_d = FETCH;
                    end
                end
                DROP: begin
                    if (imem_ack_i) begin
                        state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q       <= RESET_PC;
            inst_q     <= 32'd0;
            instPc_q   <= RESET_PC;
            valid_q    <= 1'b0;
            state_q    <= FETCH;
            dropAddr_q <= RESET_PC;
        end else begin
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            instPc_q   <= instPc_d;
            valid_q    <= valid_d;
            state_q    <= state_d;
            dropAddr_q <= dropAddr_d;
        end
    end

    assign imem_req_o    = !rst_i && ((state_q == FETCH) || (state_q == DROP));
    assign imem_addr_o   = (state_q == DROP) ? dropAddr_q : pc_q;
    assign pc_o          = instPc_q;
    assign Instruction_o = inst_q;
    assign valid_o       = valid_q;
    assign ifid_flush_o  = branch_i || (!valid_q && !stall_i);

endmodule
